// File: rtl/vram_arbiter_if.sv
// Bus bundle between the raster fetch engine, the CPU bus decoder and the RAM macro.
// Latency: none (wires only); the arbiter's timing lives in vram_arbiter.
// Backpressure: the CPU side is req/ack; the raster side is never stalled.
// Optional macro ARB_STEAL_EN adds the video_stolen signal.
interface vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
) ();
  logic          video_req;
  logic [AW-1:0] video_addr;
  logic [DW-1:0] video_rdata;
  logic          video_valid;
`ifdef ARB_STEAL_EN
  logic          video_stolen;
`endif
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  video_req, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output video_rdata, video_valid, cpu_rdata, cpu_ack, cpu_busy,
           mem_addr, mem_we, mem_wdata
`ifdef ARB_STEAL_EN
    , output video_stolen
`endif
  );

  // Requester / memory side
  modport master (
    output video_req, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  video_rdata, video_valid, cpu_rdata, cpu_ack, cpu_busy,
           mem_addr, mem_we, mem_wdata
`ifdef ARB_STEAL_EN
    , input video_stolen
`endif
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: raster fetch has priority, CPU served in free cycles.
// Latency: CPU request-to-ack minimum 3 cycles (ack 2 cycles after grant); raster data 1 cycle.
// Backpressure: CPU waits in WAIT while video_req is high; ARB_STEAL_EN bounds this to MAX_WAIT.
module vram_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 64,
  parameter int WCW      = 7
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  logic [1:0]     state;
  logic [WCW-1:0] wait_cnt;
  logic [AW-1:0]  addr_q;
  logic           we_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  cpu_rdata_q;
  logic           cpu_ack_q;
  logic           video_valid_q;
  logic           grant;

  // CPU owns the RAM this cycle: free slot, or the wait limit forces a steal
  always_comb begin
    grant = 1'b0;
    if (state == WAIT) begin
`ifdef ARB_STEAL_EN
      grant = !bus.video_req || (wait_cnt == WAIT_LIMIT);
`else
      grant = !bus.video_req;
`endif
    end
  end

  // RAM side driven only from state and latched registers, never from cpu_* inputs
  assign bus.mem_addr  = grant ? addr_q : bus.video_addr;
  assign bus.mem_we    = grant & we_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.video_rdata = bus.mem_rdata;
  assign bus.video_valid = video_valid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_busy    = (state != IDLE);

  // CPU access sequencer: latch request, wait for a slot, capture read data and ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          // the requester still holds req during the ack cycle; that is not a new request
          if (bus.cpu_req && !cpu_ack_q) begin
            addr_q   <= bus.cpu_addr;
            we_q     <= bus.cpu_we;
            wdata_q  <= bus.cpu_wdata;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (grant) begin
            state <= DONE;
          end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          // synchronous RAM returns the granted read now; writes keep the old value
          if (!we_q) begin
            cpu_rdata_q <= bus.mem_rdata;
          end
          cpu_ack_q <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Raster data is valid one cycle after a fetch that was not displaced by the CPU
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_valid_q <= 1'b0;
    end else begin
      video_valid_q <= bus.video_req && !grant;
    end
  end

`ifdef ARB_STEAL_EN
  logic video_stolen_q;
  assign bus.video_stolen = video_stolen_q;

  // Flag the raster slot that was taken by a forced CPU grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_stolen_q <= 1'b0;
    end else begin
      video_stolen_q <= grant && bus.video_req;
    end
  end
`endif
endmodule
